// File: rtl/rc_window_tracker.sv
// ---------------------------------------------------------------------------
// rc_window_tracker
//
// Consumes the one-cycle window-complete pulses (in_vld / in_f) of the RC
// statistics stage.  For every accepted window it:
//   - shifts the verdict into a HIST_DEPTH-deep history vector (bit0 = newest),
//   - advances a wrapping window index,
//   - tracks a saturating run of consecutive F=1 windows (streak_alarm),
//   - queues a report record {idx, f, hist, ones} in a small FIFO.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_vld, in_f          window pulse and its verdict (in_f used only with in_vld)
//   clear                 synchronous soft clear, same effect as reset
//   out_valid, out_ready  report handshake
//   out_win_idx, out_f,
//   out_hist, out_ones    head record of the report FIFO
//   streak_alarm          level, consecutive F=1 windows >= STREAK_TH
//   overflow              sticky, a record was dropped on a full FIFO
//   fifo_level            current FIFO occupancy
//
// Handshake: out_valid is high whenever the FIFO holds a record and the
// out_* fields show the head record.  A record is consumed on a rising edge
// where out_valid && out_ready; while out_ready is low the head is held
// stable.  out_ready with an empty FIFO does nothing.  clear suppresses both
// the push and the pop of its cycle.
// ---------------------------------------------------------------------------
module rc_window_tracker #(
  parameter int HIST_DEPTH = 8,
  parameter int STREAK_TH  = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_vld,
  input  logic                              in_f,
  input  logic                              clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_W-1:0]                  out_win_idx,
  output logic                              out_f,
  output logic [HIST_DEPTH-1:0]             out_hist,
  output logic [$clog2(HIST_DEPTH+1)-1:0]   out_ones,
  output logic                              streak_alarm,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int ONES_W = $clog2(HIST_DEPTH + 1);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STK_W  = $clog2(STREAK_TH + 1);

  // Window tracking state
  logic [HIST_DEPTH-1:0] hist;
  logic [IDX_W-1:0]      win_idx;
  logic [STK_W-1:0]      streak;
  logic                  alarm_q;
  logic                  ovf_q;

  // Report FIFO storage, one array per record field
  logic [IDX_W-1:0]      mem_idx  [FIFO_DEPTH];
  logic                  mem_f    [FIFO_DEPTH];
  logic [HIST_DEPTH-1:0] mem_hist [FIFO_DEPTH];
  logic [ONES_W-1:0]     mem_ones [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;

  function automatic logic [ONES_W-1:0] popcount(input logic [HIST_DEPTH-1:0] v);
    logic [ONES_W-1:0] c;
    c = '0;
    for (int i = 0; i < HIST_DEPTH; i++) c = c + ONES_W'(v[i]);
    return c;
  endfunction

  logic [HIST_DEPTH-1:0] new_hist;
  logic [ONES_W-1:0]     new_ones;
  logic [STK_W-1:0]      new_streak;
  logic                  accept;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  always_comb begin
    new_hist = {hist[HIST_DEPTH-2:0], in_f};
    new_ones = popcount(new_hist);
    new_streak = '0;
    if (in_f) begin
      // Saturate so a long run of F=1 cannot wrap back below the threshold
      if (streak >= STK_W'(STREAK_TH)) new_streak = streak;
      else                             new_streak = streak + STK_W'(1);
    end
    accept = in_vld && !clear;
    full   = (level == LVL_W'(FIFO_DEPTH));
    pop    = (level != '0) && out_ready && !clear;
    // A full FIFO still accepts when the head leaves on the same edge
    push   = accept && (!full || pop);
    drop   = accept && full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      win_idx <= '0;
      streak  <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx[i]  <= '0;
        mem_f[i]    <= 1'b0;
        mem_hist[i] <= '0;
        mem_ones[i] <= '0;
      end
    end else if (clear) begin
      hist    <= '0;
      win_idx <= '0;
      streak  <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx[i]  <= '0;
        mem_f[i]    <= 1'b0;
        mem_hist[i] <= '0;
        mem_ones[i] <= '0;
      end
    end else begin
      // Tracking state advances on every accepted window, dropped or not
      if (accept) begin
        hist    <= new_hist;
        win_idx <= win_idx + IDX_W'(1);
        streak  <= new_streak;
        alarm_q <= (new_streak >= STK_W'(STREAK_TH));
      end
      if (drop) ovf_q <= 1'b1;
      if (push) begin
        mem_idx[wr_ptr]  <= win_idx;
        mem_f[wr_ptr]    <= in_f;
        mem_hist[wr_ptr] <= new_hist;
        mem_ones[wr_ptr] <= new_ones;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign out_valid    = (level != '0);
  assign out_win_idx  = mem_idx[rd_ptr];
  assign out_f        = mem_f[rd_ptr];
  assign out_hist     = mem_hist[rd_ptr];
  assign out_ones     = mem_ones[rd_ptr];
  assign streak_alarm = alarm_q;
  assign overflow     = ovf_q;
  assign fifo_level   = level;

endmodule

// File: tb/tb_rc_window_tracker.sv
// ---------------------------------------------------------------------------
// tb_rc_window_tracker
//
// Directed bench for rc_window_tracker.  Inputs change 1 time unit after a
// rising edge; everything is sampled on the falling edge.  A scoreboard
// process keeps a reference model of the tracker and an expected-record
// queue, pushing on each accepted window and popping when the DUT consumes.
// ---------------------------------------------------------------------------
module tb_rc_window_tracker;

  localparam int HIST_DEPTH = 8;
  localparam int STREAK_TH  = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = 16;
  localparam int ONES_W     = $clog2(HIST_DEPTH + 1);
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int REC_W      = IDX_W + 1 + HIST_DEPTH + ONES_W;

  logic                  clk;
  logic                  rst_n;
  logic                  in_vld;
  logic                  in_f;
  logic                  clear;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_win_idx;
  logic                  out_f;
  logic [HIST_DEPTH-1:0] out_hist;
  logic [ONES_W-1:0]     out_ones;
  logic                  streak_alarm;
  logic                  overflow;
  logic [LVL_W-1:0]      fifo_level;

  int checks = 0;
  int errors = 0;

  rc_window_tracker #(
    .HIST_DEPTH(HIST_DEPTH),
    .STREAK_TH (STREAK_TH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_vld      (in_vld),
    .in_f        (in_f),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_win_idx (out_win_idx),
    .out_f       (out_f),
    .out_hist    (out_hist),
    .out_ones    (out_ones),
    .streak_alarm(streak_alarm),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [REC_W-1:0]      exp_q[$];
  logic [HIST_DEPTH-1:0] m_hist;
  logic [IDX_W-1:0]      m_idx;
  int                    m_streak;
  logic                  m_alarm;
  logic                  m_ovf;

  always @(negedge clk) begin
    logic [REC_W-1:0]      head;
    logic [HIST_DEPTH-1:0] nh;
    logic                  do_pop;
    logic                  was_full;
    if (!rst_n) begin
      exp_q.delete();
      m_hist = '0; m_idx = '0; m_streak = 0; m_alarm = 1'b0; m_ovf = 1'b0;
    end else begin
      // State produced by all edges so far
      chk("sb_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("sb_level", 32'(fifo_level), 32'(exp_q.size()));
      chk("sb_alarm", 32'(streak_alarm), 32'(m_alarm));
      chk("sb_ovf", 32'(overflow), 32'(m_ovf));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("sb_idx", 32'(out_win_idx), 32'(head[REC_W-1 -: IDX_W]));
        chk("sb_f", 32'(out_f), 32'(head[ONES_W+HIST_DEPTH]));
        chk("sb_hist", 32'(out_hist), 32'(head[ONES_W +: HIST_DEPTH]));
        chk("sb_ones", 32'(out_ones), 32'(head[ONES_W-1:0]));
      end
      // Inputs that the coming edge will act on
      if (clear) begin
        exp_q.delete();
        m_hist = '0; m_idx = '0; m_streak = 0; m_alarm = 1'b0; m_ovf = 1'b0;
      end else begin
        was_full = (exp_q.size() == FIFO_DEPTH);
        do_pop   = (exp_q.size() != 0) && out_ready;
        if (do_pop) void'(exp_q.pop_front());
        if (in_vld) begin
          nh = {m_hist[HIST_DEPTH-2:0], in_f};
          if (was_full && !do_pop) m_ovf = 1'b1;
          else exp_q.push_back({m_idx, in_f, nh, ONES_W'($countones(nh))});
          m_hist   = nh;
          m_idx    = m_idx + 1'b1;
          m_streak = in_f ? ((m_streak >= STREAK_TH) ? STREAK_TH : m_streak + 1) : 0;
          m_alarm  = (m_streak >= STREAK_TH);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic f);
    in_vld = 1'b1;
    in_f   = f;
    tick();
    in_vld = 1'b0;
    in_f   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [HIST_DEPTH-1:0] t_hist [6];
  logic [ONES_W-1:0]     t_ones [6];
  logic                  t_f    [6];
  logic [IDX_W-1:0]      t_wrap [3];

  initial begin
    t_f    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t_hist = '{8'h01, 8'h03, 8'h06, 8'h0D, 8'h1B, 8'h37};
    t_ones = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
    t_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000};

    rst_n = 1'b0; in_vld = 1'b0; in_f = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_alarm", 32'(streak_alarm), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'({out_win_idx, out_f, out_hist, out_ones}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: basic verdict sequence with an always-ready consumer
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(t_f[i]);
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_idx", 32'(out_win_idx), 32'(i));
      chk("t1_hist", 32'(out_hist), 32'(t_hist[i]));
      chk("t1_ones", 32'(out_ones), 32'(t_ones[i]));
      chk("t1_alarm", 32'(streak_alarm), (i == 5) ? 32'd1 : 32'd0);
      tick();
    end

    // 2: stalled consumer, fifth record overflows, drain keeps order
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0);
    @(negedge clk);
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_drain_idx", 32'(out_win_idx), 32'(i));
      tick();
    end
    send(1'b1);
    @(negedge clk);
    chk("t2_next_idx", 32'(out_win_idx), 32'd5);
    tick();

    // 3: push and pop on the same edge while full
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b1);
    out_ready = 1'b1;
    send(1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_head_idx", 32'(out_win_idx), 32'd1);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // 4: index wrap
    do_clear();
    in_vld = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      in_f = 1'($urandom_range(0, 1));
      tick();
    end
    in_vld = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      send(1'b0);
      @(negedge clk);
      chk("t4_wrap_idx", 32'(out_win_idx), 32'(t_wrap[i]));
      tick();
    end

    // 5: clear wins over a simultaneous pulse with records queued
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t5_pre_level", 32'(fifo_level), 32'd2);
    chk("t5_pre_alarm", 32'(streak_alarm), 32'd1);
    chk("t5_pre_ovf", 32'(overflow), 32'd1);
    tick();
    clear = 1'b1; in_vld = 1'b1; in_f = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; in_vld = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_alarm", 32'(streak_alarm), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    tick();
    send(1'b1);
    @(negedge clk);
    chk("t5_idx", 32'(out_win_idx), 32'd0);
    chk("t5_hist", 32'(out_hist), 32'h01);
    tick();

    // 6: asynchronous reset between edges
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_alarm", 32'(streak_alarm), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk("t6_data", 32'({out_win_idx, out_f, out_hist, out_ones}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_window_tracker.md
Name: rc_window_tracker

Overview:
- Sits directly downstream of the 256-cycle RC statistics stage and consumes its one-cycle Vld/F result pulses.
- Keeps a sliding history of the most recent window verdicts and a running window index.
- Raises a streak alarm after consecutive F=1 windows.
- Queues one report record per window in a small FIFO drained through a valid/ready handshake, so a slow consumer does not lose results.

Parameters:
- HIST_DEPTH, 8: number of past window verdicts kept in the history vector (2..16).
- STREAK_TH, 3: consecutive F=1 windows needed to assert streak_alarm (1..15).
- FIFO_DEPTH, 4: report FIFO entries (power of two, 2..16).
- IDX_W, 16: window index width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_vld  in  1  one-cycle window-complete pulse from statistics stage
- in_f  in  1  window verdict; sampled only when in_vld=1
- clear  in  1  synchronous soft clear
- out_valid  out  1  report record available at FIFO head
- out_ready  in  1  consumer accepts head record
- out_win_idx  out  IDX_W  index of the reported window
- out_f  out  1  verdict of the reported window
- out_hist  out  HIST_DEPTH  history after this window; bit0 = this window
- out_ones  out  clog2(HIST_DEPTH+1)  popcount of out_hist
- streak_alarm  out  1  level; consecutive F=1 count >= STREAK_TH
- overflow  out  1  sticky; a record was dropped on a full FIFO
- fifo_level  out  clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_n=0, asynchronous):
  - hist=0, win_idx=0, streak=0, FIFO empty.
  - out_valid=0, streak_alarm=0, overflow=0, fifo_level=0.
  - out_* data=0.
- Window accept (in_vld=1, clear=0), all updates on the same clock edge:
  - hist <= {hist[HIST_DEPTH-2:0], in_f}.
  - ones = popcount of the new hist.
  - win_idx increments by 1 and wraps from all-ones to 0. The record carries the pre-increment value, so the first window is index 0.
  - Streak:
    - in_f=1: streak+1, saturating at STREAK_TH.
    - in_f=0: streak=0.
  - streak_alarm is registered and equals (new streak >= STREAK_TH), so it updates 1 cycle after the in_vld edge.
  - Record {win_idx, in_f, new hist, new ones} is pushed into the FIFO.
- History fill: before HIST_DEPTH windows have been seen, unfilled positions read 0 and out_ones counts only real 1s.
- FIFO and handshake:
  - out_valid = (level != 0); head data drives out_* directly from FIFO storage.
  - Pop occurs when out_valid && out_ready.
  - A record pushed at edge N is visible with out_valid=1 after edge N, i.e. 1-cycle latency.
  - While out_valid=1 and out_ready=0, out_* are held stable.
  - out_ready while empty has no effect.
- Boundary: full FIFO
  - Push without pop: the record is dropped, overflow is set and stays set until reset or clear. hist, idx and streak still update.
  - Push and pop on the same cycle while full: both happen, level is unchanged, no overflow.
  - Push and pop on the same cycle while partially full: level is unchanged and order is preserved.
- Back-to-back in_vld pulses, one per cycle, must each be processed; no minimum spacing is required.
- clear=1 (synchronous):
  - Same effect as reset on the next edge.
  - clear has priority over in_vld and out_ready in the same cycle; that pulse is discarded and no pop occurs.
- in_f is ignored when in_vld=0.

Test Plan:
- Reset, then pulses F=1,1,0,1,1,1 with out_ready=1. Required records:
  - idx 0..5; hist low bits 0x01,0x03,0x06,0x0D,0x1B,0x37; ones 1,2,2,3,4,5.
  - streak_alarm rises 1 cycle after the 6th pulse, not earlier.
  - After the 3rd pulse (F=0), streak_alarm is 0.
- Hold out_ready=0 and send 5 pulses with FIFO_DEPTH=4:
  - fifo_level reaches 4, the 5th record is dropped and overflow=1.
  - Draining then yields idx 0..3 in order.
  - hist/idx continue, so the next record has idx 5.
- FIFO full with out_ready=1 and in_vld=1 on the same cycle: head idx pops, new record is appended, level stays 4, overflow stays 0.
- Preload win_idx to 0xFFFE by sending 65534 pulses while draining, then 3 more pulses: records carry idx 0xFFFE, 0xFFFF, 0x0000.
- Mid-stream, with 2 records queued, streak_alarm=1 and overflow=1, assert clear together with in_vld=1:
  - Next cycle: out_valid=0, fifo_level=0, streak_alarm=0, overflow=0.
  - The next pulse reports idx 0 with hist=0x01.
- Assert rst_n=0 asynchronously between clock edges while records are queued: all outputs go to 0 immediately, without waiting for a clock edge.
